// File: rtl/blackjack_deck_dealer.sv
// Builds a 52-card Blackjack deck, Fisher-Yates shuffles it with an LFSR, and deals one card per request.
// Latency: card_valid one cycle after card_req; no backpressure, requests outside READY are dropped.
`timescale 1ns/1ps
module blackjack_deck_dealer #(
  parameter int                 DECK_SIZE = 52,
  parameter int                 CARD_W    = 4,
  parameter int                 LFSR_W    = 16,
  parameter logic [LFSR_W-1:0]  LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shuffle_start,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              card_req,
  output logic              card_valid,
  output logic [CARD_W-1:0] card,
  output logic [6:0]        deck_pos,
  output logic              deck_ready,
  output logic              deck_empty,
  output logic              shuffle_busy,
  input  logic [5:0]        dbg_addr,
  output logic [CARD_W-1:0] dbg_card
);

  localparam logic [5:0] LAST_IDX = 6'(DECK_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SHUFFLE,
    S_READY,
    S_EMPTY
  } state_t;

  state_t              state, state_nxt;
  logic [CARD_W-1:0]   deck [DECK_SIZE];
  logic [5:0]          idx;
  logic [LFSR_W-1:0]   lfsr;
  logic [LFSR_W-1:0]   lfsr_step;
  logic [5:0]          cand;
  logic                accept_swap;
  logic                can_cmd;
  logic                deal;
  logic [3:0]          fill_grp;
  logic [CARD_W-1:0]   fill_val;

  // x^16+x^14+x^13+x^11+1, shifted left with feedback into bit 0
  assign lfsr_step   = {lfsr[LFSR_W-2:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign cand        = lfsr[5:0];
  assign accept_swap = (state == S_SHUFFLE) && (cand <= idx);
  assign can_cmd     = (state == S_IDLE) || (state == S_READY) || (state == S_EMPTY);
  assign deal        = (state == S_READY) && card_req && !shuffle_start;

  assign fill_grp = idx[5:2];
  assign fill_val = (fill_grp >= 4'd9) ? CARD_W'(10) : CARD_W'(fill_grp + 4'd1);

  assign deck_ready   = (state == S_READY);
  assign deck_empty   = (state == S_EMPTY);
  assign shuffle_busy = (state == S_FILL) || (state == S_SHUFFLE);
  assign dbg_card     = (dbg_addr <= LAST_IDX) ? deck[dbg_addr] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_EMPTY: begin
        if (shuffle_start) state_nxt = S_FILL;
      end
      S_READY: begin
        if (shuffle_start) begin
          state_nxt = S_FILL;
        end else if (card_req && (deck_pos == 7'(DECK_SIZE - 1))) begin
          state_nxt = S_EMPTY;
        end
      end
      S_FILL: begin
        if (idx == LAST_IDX) state_nxt = S_SHUFFLE;
      end
      S_SHUFFLE: begin
        if (accept_swap && (idx == 6'd1)) state_nxt = S_READY;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr       <= LFSR_SEED;
      idx        <= '0;
      deck_pos   <= '0;
      card       <= '0;
      card_valid <= 1'b0;
      for (int k = 0; k < DECK_SIZE; k++) deck[k] <= '0;
    end else begin
      card_valid <= 1'b0;
      // A seed load in the same cycle as shuffle_start lands before the first LFSR step
      if (can_cmd && seed_load) begin
        lfsr <= (seed_in == '0) ? LFSR_SEED : seed_in;
      end
      if (can_cmd && shuffle_start) begin
        idx      <= '0;
        deck_pos <= '0;
      end else if (deal) begin
        card_valid <= 1'b1;
        card       <= deck[deck_pos[5:0]];
        deck_pos   <= deck_pos + 7'd1;
      end
      if (state == S_FILL) begin
        deck[idx] <= fill_val;
        if (idx != LAST_IDX) idx <= idx + 6'd1;
      end
      if (state == S_SHUFFLE) begin
        lfsr <= lfsr_step;
        if (accept_swap) begin
          deck[idx]  <= deck[cand];
          deck[cand] <= deck[idx];
          idx        <= idx - 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_blackjack_deck_dealer.sv
// Directed bench for blackjack_deck_dealer: reset, fill/shuffle, dealing, determinism and override cases.
`timescale 1ns/1ps
module tb_blackjack_deck_dealer;

  logic        clk = 1'b0;
  logic        reset;
  logic        shuffle_start;
  logic        seed_load;
  logic [15:0] seed_in;
  logic        card_req;
  logic        card_valid;
  logic [3:0]  card;
  logic [6:0]  deck_pos;
  logic        deck_ready;
  logic        deck_empty;
  logic        shuffle_busy;
  logic [5:0]  dbg_addr;
  logic [3:0]  dbg_card;

  int checks   = 0;
  int failures = 0;

  logic [3:0] snap     [52];
  logic [3:0] snap_a   [52];
  logic [3:0] snap_b   [52];
  logic [3:0] exp_deck [52];
  int         exp_steps;

  always #5 clk = ~clk;

  blackjack_deck_dealer dut (
    .clk          (clk),
    .reset        (reset),
    .shuffle_start(shuffle_start),
    .seed_load    (seed_load),
    .seed_in      (seed_in),
    .card_req     (card_req),
    .card_valid   (card_valid),
    .card         (card),
    .deck_pos     (deck_pos),
    .deck_ready   (deck_ready),
    .deck_empty   (deck_empty),
    .shuffle_busy (shuffle_busy),
    .dbg_addr     (dbg_addr),
    .dbg_card     (dbg_card)
  );

  // Reference Fisher-Yates: sorted deck, then swap walk driven by the LFSR
  task automatic model_shuffle(input logic [15:0] seed);
    logic [15:0] l;
    logic [3:0]  t;
    int          i;
    int          j;
    for (int k = 0; k < 52; k++) exp_deck[k] = (k / 4 + 1 > 10) ? 4'd10 : 4'(k / 4 + 1);
    l = (seed == 16'h0) ? 16'hACE1 : seed;
    i = 51;
    exp_steps = 0;
    while (exp_steps < 10000) begin
      j = int'(l[5:0]);
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      exp_steps++;
      if (j <= i) begin
        t = exp_deck[i]; exp_deck[i] = exp_deck[j]; exp_deck[j] = t;
        if (i == 1) break;
        i--;
      end
    end
  endtask

  task automatic take_snapshot();
    for (int a = 0; a < 52; a++) begin
      dbg_addr = 6'(a);
      #1;
      snap[a] = dbg_card;
    end
    dbg_addr = 6'd0;
    @(negedge clk);
  endtask

  task automatic run_shuffle(input logic [15:0] seed, input bit load, input bit together,
                             input int poke_at, output bit first_busy,
                             output int busy_cycles, output bit timed_out);
    seed_in = seed;
    if (load && !together) begin
      seed_load = 1'b1;
      @(negedge clk);
      seed_load = 1'b0;
    end
    if (load && together) seed_load = 1'b1;
    shuffle_start = 1'b1;
    @(negedge clk);
    shuffle_start = 1'b0;
    seed_load     = 1'b0;
    first_busy    = shuffle_busy;
    busy_cycles   = 0;
    timed_out     = 1'b0;
    while (shuffle_busy && !timed_out) begin
      busy_cycles++;
      if (busy_cycles == poke_at) begin
        shuffle_start = 1'b1;
        seed_load     = 1'b1;
        seed_in       = 16'h5555;
      end else begin
        shuffle_start = 1'b0;
        seed_load     = 1'b0;
      end
      @(negedge clk);
      if (busy_cycles > 4000) timed_out = 1'b1;
    end
    shuffle_start = 1'b0;
    seed_load     = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b1; shuffle_start = 0; seed_load = 0; seed_in = 0; card_req = 0; dbg_addr = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({card_valid, deck_ready, deck_empty, shuffle_busy} !== 4'b0000 || deck_pos !== 7'd0 || card !== 4'd0) begin
      failures++;
      $display("FAIL reset_outputs: flags=%b deck_pos=%0d card=%0d, required flags=0000 deck_pos=0 card=0",
               {card_valid, deck_ready, deck_empty, shuffle_busy}, deck_pos, card);
    end
    bad = 0;
    for (int a = 0; a < 52; a++) begin
      dbg_addr = 6'(a);
      #1;
      if (dbg_card !== 4'd0) bad++;
    end
    dbg_addr = 6'd0;
    @(negedge clk);
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_deck: %0d nonzero entries, required 0", bad);
    end
  endtask

  task automatic test_shuffle();
    bit   first_busy, timed_out;
    int   busy, bad;
    int   hist [11];
    bit   sorted_same;
    model_shuffle(16'h0079);
    run_shuffle(16'h0079, 1'b1, 1'b0, 0, first_busy, busy, timed_out);
    checks++;
    if (first_busy !== 1'b1) begin
      failures++; $display("FAIL shuffle_busy_start: got %b, required 1", first_busy);
    end
    checks++;
    if (timed_out || busy != 52 + exp_steps) begin
      failures++; $display("FAIL shuffle_duration: busy=%0d timeout=%0d, required %0d", busy, timed_out, 52 + exp_steps);
    end
    checks++;
    if (deck_ready !== 1'b1 || deck_empty !== 1'b0 || deck_pos !== 7'd0) begin
      failures++; $display("FAIL shuffle_ready: ready=%b empty=%b pos=%0d, required 1 0 0", deck_ready, deck_empty, deck_pos);
    end
    take_snapshot();
    snap_a = snap;
    foreach (hist[v]) hist[v] = 0;
    bad = 0;
    sorted_same = 1'b1;
    for (int k = 0; k < 52; k++) begin
      if (snap[k] >= 4'd1 && snap[k] <= 4'd10) hist[snap[k]]++; else hist[0]++;
      if (snap[k] !== exp_deck[k]) bad++;
      if (snap[k] !== ((k / 4 + 1 > 10) ? 4'd10 : 4'(k / 4 + 1))) sorted_same = 1'b0;
    end
    checks++;
    if (hist[0] != 0 || hist[10] != 16 || hist[1] != 4 || hist[5] != 4 || hist[9] != 4) begin
      failures++; $display("FAIL shuffle_histogram: bad=%0d ones=%0d fives=%0d nines=%0d tens=%0d, required 0 4 4 4 16",
                           hist[0], hist[1], hist[5], hist[9], hist[10]);
    end
    checks++;
    if (sorted_same) begin
      failures++; $display("FAIL shuffle_unsorted: deck still sorted, required a permuted order");
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL shuffle_model: %0d entries differ from reference, required 0", bad);
    end
    dbg_addr = 6'd52; #1;
    checks++;
    if (dbg_card !== 4'd0) begin
      failures++; $display("FAIL dbg_out_of_range52: got %0d, required 0", dbg_card);
    end
    dbg_addr = 6'd63; #1;
    checks++;
    if (dbg_card !== 4'd0) begin
      failures++; $display("FAIL dbg_out_of_range63: got %0d, required 0", dbg_card);
    end
    dbg_addr = 6'd0;
    @(negedge clk);
  endtask

  task automatic test_deal_all();
    int bad_v, bad_c;
    bit exp_v;
    bad_v = 0; bad_c = 0;
    for (int c = 0; c <= 53; c++) begin
      if (c >= 1) begin
        exp_v = (c <= 52);
        if (card_valid !== exp_v) bad_v++;
        if (exp_v && (card !== snap_a[c-1] || deck_pos !== 7'(c))) bad_c++;
      end
      card_req = (c <= 52);
      @(negedge clk);
    end
    card_req = 1'b0;
    checks++;
    if (bad_v != 0) begin
      failures++; $display("FAIL deal_valid_timing: %0d cycles wrong, required 0", bad_v);
    end
    checks++;
    if (bad_c != 0) begin
      failures++; $display("FAIL deal_sequence: %0d cards/positions wrong, required 0", bad_c);
    end
    checks++;
    if (deck_empty !== 1'b1 || deck_ready !== 1'b0 || deck_pos !== 7'd52 || card_valid !== 1'b0) begin
      failures++; $display("FAIL deal_empty: empty=%b ready=%b pos=%0d valid=%b, required 1 0 52 0",
                           deck_empty, deck_ready, deck_pos, card_valid);
    end
    checks++;
    if (card !== snap_a[51]) begin
      failures++; $display("FAIL deal_card_hold: got %0d, required %0d", card, snap_a[51]);
    end
  endtask

  task automatic test_determinism();
    bit first_busy, timed_out;
    int busy, bad;
    run_shuffle(16'h0079, 1'b1, 1'b0, 0, first_busy, busy, timed_out);
    take_snapshot();
    bad = 0;
    for (int k = 0; k < 52; k++) if (snap[k] !== snap_a[k]) bad++;
    checks++;
    if (timed_out || bad != 0) begin
      failures++; $display("FAIL repeat_seed: %0d entries differ timeout=%0d, required 0", bad, timed_out);
    end
    model_shuffle(16'h0000);
    run_shuffle(16'h0000, 1'b1, 1'b1, 0, first_busy, busy, timed_out);
    take_snapshot();
    snap_b = snap;
    bad = 0;
    for (int k = 0; k < 52; k++) if (snap[k] !== exp_deck[k]) bad++;
    checks++;
    if (timed_out || bad != 0 || busy != 52 + exp_steps) begin
      failures++; $display("FAIL seed_zero_same_cycle: %0d differ busy=%0d, required 0 and %0d", bad, busy, 52 + exp_steps);
    end
    run_shuffle(16'hACE1, 1'b1, 1'b0, 0, first_busy, busy, timed_out);
    take_snapshot();
    bad = 0;
    for (int k = 0; k < 52; k++) if (snap[k] !== snap_b[k]) bad++;
    checks++;
    if (timed_out || bad != 0) begin
      failures++; $display("FAIL seed_ace1_vs_zero: %0d entries differ, required 0", bad);
    end
  endtask

  task automatic test_ready_override();
    int bad;
    bad = 0;
    card_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (card_valid !== 1'b1 || card !== snap_b[c]) bad++;
    end
    checks++;
    if (bad != 0 || deck_pos !== 7'd3) begin
      failures++; $display("FAIL three_deals: %0d bad, pos=%0d, required 0 bad pos=3", bad, deck_pos);
    end
    shuffle_start = 1'b1;
    @(negedge clk);
    shuffle_start = 1'b0;
    card_req      = 1'b0;
    checks++;
    if (card_valid !== 1'b0 || deck_pos !== 7'd0 || shuffle_busy !== 1'b1) begin
      failures++; $display("FAIL shuffle_beats_req: valid=%b pos=%0d busy=%b, required 0 0 1",
                           card_valid, deck_pos, shuffle_busy);
    end
    bad = 0;
    while (shuffle_busy && bad < 4000) begin
      bad++;
      @(negedge clk);
    end
    checks++;
    if (deck_ready !== 1'b1) begin
      failures++; $display("FAIL override_completes: ready=%b after %0d cycles, required 1", deck_ready, bad);
    end
  endtask

  task automatic test_ignore_mid_shuffle();
    bit first_busy, timed_out;
    int busy, bad;
    model_shuffle(16'h1234);
    run_shuffle(16'h1234, 1'b1, 1'b0, 60, first_busy, busy, timed_out);
    checks++;
    if (timed_out || busy != 52 + exp_steps || deck_pos !== 7'd0) begin
      failures++; $display("FAIL mid_shuffle_start_ignored: busy=%0d pos=%0d, required %0d and 0",
                           busy, deck_pos, 52 + exp_steps);
    end
    take_snapshot();
    bad = 0;
    for (int k = 0; k < 52; k++) if (snap[k] !== exp_deck[k]) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL mid_shuffle_seed_ignored: %0d entries differ, required 0", bad);
    end
  endtask

  task automatic test_reset_mid_shuffle();
    int bad;
    card_req = 1'b1;
    @(negedge clk);
    card_req = 1'b0;
    shuffle_start = 1'b1;
    @(negedge clk);
    shuffle_start = 1'b0;
    repeat (70) @(negedge clk);
    checks++;
    if (shuffle_busy !== 1'b1 || card === 4'd0) begin
      failures++; $display("FAIL pre_reset_busy: busy=%b card=%0d, required busy=1 card nonzero", shuffle_busy, card);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({card_valid, deck_ready, deck_empty, shuffle_busy} !== 4'b0000 || deck_pos !== 7'd0 || card !== 4'd0) begin
      failures++; $display("FAIL async_reset_outputs: flags=%b pos=%0d card=%0d, required 0000 0 0",
                           {card_valid, deck_ready, deck_empty, shuffle_busy}, deck_pos, card);
    end
    bad = 0;
    for (int a = 0; a < 52; a++) begin
      dbg_addr = 6'(a);
      #0.05;
      if (dbg_card !== 4'd0) bad++;
    end
    dbg_addr = 6'd0;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL async_reset_deck: %0d nonzero entries, required 0", bad);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (shuffle_busy !== 1'b0 || deck_ready !== 1'b0 || deck_pos !== 7'd0) begin
      failures++; $display("FAIL post_reset_idle: busy=%b ready=%b pos=%0d, required 0 0 0",
                           shuffle_busy, deck_ready, deck_pos);
    end
  endtask

  initial begin
    test_reset();
    test_shuffle();
    test_deal_all();
    test_determinism();
    test_ready_override();
    test_ignore_mid_shuffle();
    test_reset_mid_shuffle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
